// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//
// Shared definitions for the two-requester APB arbitrating master:
//   - apb_state_e   : bus-phase state of the master FSM (IDLE/SETUP/ACCESS)
//   - APB_ADDR_W    : default paddr / request address width
//   - APB_DATA_W    : default pwdata / prdata / request data width
//   - idx_to_onehot : turns a 1-bit requester index into a 2-bit one-hot
//                     vector, used for the req_gnt and rsp_valid pulses
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// ---------------------------------------------------------------------------
// apb_arb_master_if
//
// Bundles the requester-side handshake and the APB bus of apb_arb_master.
//
// Requester side (2 requesters, requester i owns slice i of each vector):
//   req_valid[1:0]        transfer request
//   req_write[1:0]        direction, 1 = write
//   req_addr[2*ADDR_W]    request address, slice [i*ADDR_W +: ADDR_W]
//   req_wdata[2*DATA_W]   write data, slice [i*DATA_W +: DATA_W]
//   req_gnt[1:0]          one-cycle pulse: request accepted and latched
//   rsp_valid[1:0]        one-cycle pulse: transfer completed
//   rsp_rdata[DATA_W]     read data, valid while rsp_valid != 0
//   busy                  master FSM is not IDLE
//
// APB side (no pready, no pslverr):
//   paddr, psel, penable, pwrite, pwdata driven by the master
//   prdata driven by the slave
//
// Modports:
//   master : the view of apb_arb_master itself
//   slave  : the view of the surrounding environment (requesters + slave)
// ---------------------------------------------------------------------------
interface apb_arb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_gnt;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                busy;

    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W-1:0]   prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata,
        output req_gnt, rsp_valid, rsp_rdata, busy,
               paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata,
        input  req_gnt, rsp_valid, rsp_rdata, busy,
               paddr, psel, penable, pwrite, pwdata
    );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Two-way round-robin selector, purely combinational.
//
// Ports:
//   req[1:0]  input   pending requests
//   last      input   index of the requester granted most recently
//   gnt_idx   output  index of the selected requester (meaningful when any=1)
//   any       output  at least one request is pending
//
// With both requesting, the one not granted last wins; with a single
// request, that requester wins regardless of last.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    always_comb begin
        any     = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/apb_arb_master.sv
// ---------------------------------------------------------------------------
// apb_arb_master
//
// APB master shared by two requesters through a round-robin arbiter.
// Each transfer runs SETUP (psel=1, penable=0, req_gnt pulse) then ACCESS
// (psel=1, penable=1); the bus has no wait states, so ACCESS always lasts
// one cycle. The response (rsp_valid pulse, plus rsp_rdata for a read)
// appears in the cycle after ACCESS. If another request is pending at the
// end of ACCESS the master goes straight back to SETUP, keeping psel high.
//
// Parameters:
//   ADDR_W  address width (paddr, each req_addr slice)
//   DATA_W  data width (pwdata, prdata, rsp_rdata, each req_wdata slice)
//
// Ports:
//   pclk    clock, rising edge
//   rst     synchronous, active-high reset
//   bus     apb_arb_master_if.master: requester handshake + APB signals
//
// Every output is a flop except busy, which decodes the state register.
// ---------------------------------------------------------------------------
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) (
    input  logic             pclk,
    input  logic             rst,
    apb_arb_master_if.master bus
);

    apb_state_e        state_q,     state_d;
    logic              last_q,      last_d;
    logic              winner_q,    winner_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [1:0]        req_gnt_q,   req_gnt_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              arb_idx;
    logic              arb_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;

    rr_arb2 u_rr_arb2 (
        .req     (bus.req_valid),
        .last    (last_q),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Fields of whichever requester the arbiter currently favours; only
    // consumed on the edges where a grant is actually issued.
    always_comb begin
        sel_addr  = bus.req_addr[ADDR_W-1:0];
        sel_wdata = bus.req_wdata[DATA_W-1:0];
        sel_write = bus.req_write[0];
        if (arb_idx) begin
            sel_addr  = bus.req_addr[2*ADDR_W-1:ADDR_W];
            sel_wdata = bus.req_wdata[2*DATA_W-1:DATA_W];
            sel_write = bus.req_write[1];
        end
    end

    // Next-state and registered-output logic. Request fields are looked at
    // only in IDLE and on the edge leaving ACCESS, which is why those two
    // branches share the grant path.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        winner_d    = winner_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        req_gnt_d   = 2'b00;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (arb_any) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = sel_addr;
                    pwrite_d  = sel_write;
                    pwdata_d  = sel_wdata;
                    winner_d  = arb_idx;
                    last_d    = arb_idx;
                    req_gnt_d = idx_to_onehot(arb_idx);
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end

            ACCESS: begin
                // A write leaves the previous read data in place.
                if (!pwrite_q) begin
                    rsp_rdata_d = bus.prdata;
                end
                rsp_valid_d = idx_to_onehot(winner_q);
                if (arb_any) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = sel_addr;
                    pwrite_d  = sel_write;
                    pwdata_d  = sel_wdata;
                    winner_d  = arb_idx;
                    last_d    = arb_idx;
                    req_gnt_d = idx_to_onehot(arb_idx);
                end else begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // last_q resets to 1 so that requester 0 wins the first contention.
    // Reset during SETUP/ACCESS simply drops the transfer: no response.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            winner_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            req_gnt_q   <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            req_gnt_q   <= req_gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.req_gnt   = req_gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8: paddr and request address width.
REQ-002 The module SHALL have parameter DATA_W, default 32: pwdata, prdata and request/response data width.
REQ-003 The module SHALL have port pclk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port req_valid, input, 2 bits: per-requester transfer request.
REQ-006 The module SHALL have port req_write, input, 2 bits: per-requester direction, 1 = write.
REQ-007 The module SHALL have port req_addr, input, 2*ADDR_W bits: requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-008 The module SHALL have port req_wdata, input, 2*DATA_W bits: requester i uses slice [i*DATA_W +: DATA_W].
REQ-009 The module SHALL have port req_gnt, output, 2 bits: one-cycle pulse meaning the request was accepted and latched.
REQ-010 The module SHALL have port rsp_valid, output, 2 bits: one-cycle pulse meaning the transfer completed.
REQ-011 The module SHALL have port rsp_rdata, output, DATA_W bits: read data, valid while rsp_valid is non-zero.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The module SHALL have APB master ports paddr (ADDR_W), psel (1), penable (1), pwrite (1) and pwdata (DATA_W) as outputs, and prdata (DATA_W) as an input; the bus carries no pready and no pslverr.

Function
REQ-014 The module SHALL implement a three-state FSM: IDLE, SETUP and ACCESS.
REQ-015 In IDLE, when req_valid != 0 at a rising edge, the module SHALL select a winner, latch the winner's addr, wdata and write fields, and enter SETUP; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both requesters valid, the requester not granted last wins; with one requester valid, that requester wins.
REQ-017 The last-grant pointer SHALL update only when a grant is issued.
REQ-018 In SETUP, the outputs SHALL be psel=1 and penable=0, paddr/pwrite/pwdata SHALL carry the latched values, and req_gnt[winner] SHALL be 1 for this cycle only; the next state SHALL be ACCESS unconditionally.
REQ-019 In ACCESS, the outputs SHALL be psel=1 and penable=1 with paddr/pwrite/pwdata unchanged; the access SHALL complete in exactly one cycle.
REQ-020 At the edge ending ACCESS, the module SHALL register prdata into rsp_rdata for a read (and keep the previous value for a write), and rsp_valid[winner] SHALL pulse in the following cycle.
REQ-021 At the edge ending ACCESS, if req_valid != 0 the module SHALL re-arbitrate and go directly to SETUP (back-to-back transfer, psel held high); otherwise it SHALL go to IDLE with psel=0 and penable=0.
REQ-022 Each requester SHALL hold req_valid and its fields stable until it sees req_gnt, and SHALL drop or change them by the edge ending the gnt cycle.
REQ-023 Latency SHALL be: accept edge -> SETUP (gnt) -> ACCESS -> rsp_valid, i.e. rsp_valid occurs 3 cycles after the accepting edge.
REQ-024 At most one bit of req_gnt and at most one bit of rsp_valid SHALL be set in any cycle.
REQ-025 penable SHALL never be 1 while psel is 0.
REQ-026 Request fields SHALL NOT be sampled in SETUP or ACCESS except at the edge ending ACCESS.
REQ-027 While in IDLE, paddr, pwrite and pwdata SHALL hold their last values.
REQ-028 All outputs SHALL be registered, except busy, which is a decode of the state register.

Reset
REQ-029 While rst=1 at an edge, the module SHALL force state=IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, req_gnt=0, rsp_valid=0, rsp_rdata=0 and busy=0.
REQ-030 Reset SHALL set the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-031 A reset asserted during SETUP or ACCESS SHALL abort the transfer: no rsp_valid is issued and psel drops at that edge.
REQ-032 The first grant after reset SHALL occur no earlier than the first edge with rst=0.

Structure
REQ-033 Package apb_pkg SHALL hold the typedef apb_state_e (IDLE/SETUP/ACCESS) and the default ADDR_W/DATA_W localparams.
REQ-034 Round-robin selection SHALL be one sub-module, rr_arb2 (inputs: req[1:0], last; outputs: gnt_idx, any), instantiated once.

Verification
REQ-035 The bench SHALL cover: reset release, then a write from requester 0 with addr=0x10 and wdata=0xDEADBEEF -> req_gnt=01 in SETUP, psel/penable sequence 10 then 11, rsp_valid=01 three cycles after accept.
REQ-036 The bench SHALL cover: requester 1 reads addr=0x10 after that write -> rsp_rdata=0xDEADBEEF with rsp_valid=10.
REQ-037 The bench SHALL cover: both requesters valid continuously for 4 transfers -> grant order 0,1,0,1 with psel never dropping between transfers.
REQ-038 The bench SHALL cover: rst=1 asserted in the ACCESS cycle -> next cycle psel=0, penable=0, rsp_valid=00, state IDLE.
REQ-039 The bench SHALL cover: a single requester issuing 3 back-to-back writes to addresses 0x00, 0x04 and 0x08 -> three SETUP/ACCESS pairs, no IDLE cycle between them, busy continuously high.
REQ-040 The bench SHALL check on every cycle: req_gnt and rsp_valid each one-hot or zero, and penable implies psel.
